// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and arithmetic helpers for the
// token calculator engine.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_EQ  = 4'hE;

  // Helpers work at a fixed wide width; callers truncate to their own WIDTH,
  // which keeps results exact modulo 2^WIDTH for any WIDTH up to MAX_W.
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE_OP,
    S_REDUCE_ALL,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [1:0] prec(input logic [3:0] op);
    case (op)
      OP_MUL:         return 2'd2;
      OP_ADD, OP_SUB: return 2'd1;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] apply_op(input logic [3:0] op,
                                                input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// LIFO with combined pop(0..2)-then-push per cycle; exposes the top two entries.
module lifo_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [1:0]                   pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             top_o,
  output logic [WIDTH-1:0]             next_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d, base;
  logic             do_push;

  always_comb begin
    base    = (CW'(pop_i) > count_q) ? '0 : count_q - CW'(pop_i);
    do_push = push_i && (base < CW'(DEPTH));
    count_d = do_push ? base + CW'(1) : base;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Storage needs no reset: entries at or above count are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[IW'(base)] <= data_i;
  end

  always_comb begin
    top_o  = '0;
    next_o = '0;
    if (count_q >= CW'(1)) top_o  = mem_q[IW'(count_q - CW'(1))];
    if (count_q >= CW'(2)) next_o = mem_q[IW'(count_q - CW'(2))];
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/token_calc_engine.sv
// Infix calculator: evaluates a number/operator token stream with
// multiply-over-add precedence using a number stack and an operator stack.
module token_calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [WIDTH-1:0] token,
  input  logic             token_is_op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] answer,
  output logic             error
);
  localparam int CW = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [3:0]       pending_q, pending_d;
  logic             expect_num_q, expect_num_d;
  logic [WIDTH-1:0] answer_q, answer_d;
  logic             ready_q, done_q, error_q;

  logic             num_push, num_full, num_empty;
  logic [1:0]       num_pop;
  logic [WIDTH-1:0] num_din, num_top, num_next, reduce_val;
  logic [CW-1:0]    num_count;
  logic             op_push, op_pop, op_full, op_empty;
  logic [3:0]       op_top, op_next;
  logic [CW-1:0]    op_count;
  logic             unused_stack_status;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_num (
    .clk(clk), .reset(reset), .push_i(num_push), .pop_i(num_pop),
    .data_i(num_din), .top_o(num_top), .next_o(num_next),
    .count_o(num_count), .full_o(num_full), .empty_o(num_empty)
  );

  lifo_stack #(.WIDTH(4), .DEPTH(DEPTH)) u_op (
    .clk(clk), .reset(reset), .push_i(op_push), .pop_i({1'b0, op_pop}),
    .data_i(pending_q), .top_o(op_top), .next_o(op_next),
    .count_o(op_count), .full_o(op_full), .empty_o(op_empty)
  );

  assign unused_stack_status = ^{num_count, op_count, op_next, num_empty};
  assign reduce_val = WIDTH'(apply_op(op_top, MAX_W'(num_next), MAX_W'(num_top)));

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    expect_num_d = expect_num_q;
    answer_d     = answer_q;
    num_push     = 1'b0;
    num_pop      = 2'd0;
    num_din      = token;
    op_push      = 1'b0;
    op_pop       = 1'b0;
    case (state_q)
      S_IDLE: if (strobe) begin
        if (!token_is_op) begin
          if (!expect_num_q || num_full) state_d = S_ERR;
          else begin
            num_push     = 1'b1;
            expect_num_d = 1'b0;
          end
        end else if (expect_num_q ||
                     !(token[3:0] inside {OP_ADD, OP_SUB, OP_MUL, OP_EQ})) begin
          state_d = S_ERR;
        end else if (token[3:0] == OP_EQ) begin
          state_d = S_REDUCE_ALL;
        end else begin
          pending_d    = token[3:0];
          expect_num_d = 1'b1;
          state_d      = S_REDUCE_OP;
        end
      end
      S_REDUCE_OP: begin
        if (!op_empty && (prec(op_top) >= prec(pending_q))) begin
          op_pop   = 1'b1;
          num_pop  = 2'd2;
          num_push = 1'b1;
          num_din  = reduce_val;
        end else if (op_full) begin
          state_d = S_ERR;
        end else begin
          op_push = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_REDUCE_ALL: begin
        if (!op_empty) begin
          op_pop   = 1'b1;
          num_pop  = 2'd2;
          num_push = 1'b1;
          num_din  = reduce_val;
        end else begin
          answer_d = num_top;
          state_d  = S_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      expect_num_q <= 1'b1;
      answer_q     <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      expect_num_q <= expect_num_d;
      answer_q     <= answer_d;
      ready_q      <= (state_d == S_IDLE);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERR);
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign answer = answer_q;
  assign error  = error_q;

endmodule

// File: tb/tb_token_calc_engine.sv
// Directed bench for token_calc_engine: vector table plus timing/reset sequences.
module tb_token_calc_engine;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        strobe = 1'b0;
  logic        token_is_op = 1'b0;
  logic [31:0] token = '0;
  logic        ready, done, error;
  logic [31:0] answer;
  logic        ready2, done2, error2;
  logic [31:0] answer2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  token_calc_engine #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .token(token),
    .token_is_op(token_is_op), .ready(ready), .done(done),
    .answer(answer), .error(error)
  );

  token_calc_engine #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .strobe(strobe), .token(token),
    .token_is_op(token_is_op), .ready(ready2), .done(done2),
    .answer(answer2), .error(error2)
  );

  always @(posedge clk) begin
    if (!reset && (int'(dut.u_num.pop_i) > int'(dut.u_num.count_o) ||
                   int'(dut.u_op.pop_i) > int'(dut.u_op.count_o))) begin
      errors++;
      $display("FAIL stack_underflow at %0t", $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    int              n;
    logic [7:0][32:0] tok;
    logic [31:0]     ans;
    logic            err;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [32:0] N(input logic [31:0] v);
    return {1'b0, v};
  endfunction
  function automatic logic [32:0] O(input logic [3:0] c);
    return {1'b1, 28'h0, c};
  endfunction

  task automatic add_vec(input logic [31:0] ans, input logic err, input int n,
                         input logic [32:0] t0, input logic [32:0] t1,
                         input logic [32:0] t2 = '0, input logic [32:0] t3 = '0,
                         input logic [32:0] t4 = '0, input logic [32:0] t5 = '0,
                         input logic [32:0] t6 = '0, input logic [32:0] t7 = '0);
    vec_t v;
    v.n = n; v.ans = ans; v.err = err;
    v.tok[0] = t0; v.tok[1] = t1; v.tok[2] = t2; v.tok[3] = t3;
    v.tok[4] = t4; v.tok[5] = t5; v.tok[6] = t6; v.tok[7] = t7;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // Waits for ready (or a terminal state, where the strobe must be ignored).
  task automatic send(input logic [32:0] t);
    int w = 0;
    @(negedge clk);
    while (!ready && !error && !done && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      checks++; errors++;
      $display("FAIL send_wait ready=%0b required=1", ready);
    end
    token = t[31:0]; token_is_op = t[32]; strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
  endtask

  task automatic wait_end();
    int c = 0;
    while (!done && !error && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 40) begin
      checks++; errors++;
      $display("FAIL wait_end done=%0b error=%0b required=1", done, error);
    end
  endtask

  initial begin
    int n;
    vec_t v;
    add_vec(32'd14, 1'b0, 6, N(2), O(OP_ADD), N(3), O(OP_MUL), N(4), O(OP_EQ));
    add_vec(32'd3,  1'b0, 6, N(10), O(OP_SUB), N(4), O(OP_SUB), N(3), O(OP_EQ));
    add_vec(32'd23, 1'b0, 6, N(5), O(OP_MUL), N(6), O(OP_SUB), N(7), O(OP_EQ));
    add_vec(32'd1,  1'b0, 4, N(32'hFFFFFFFF), O(OP_ADD), N(2), O(OP_EQ));
    add_vec(32'd0,  1'b0, 4, N(32'h10000), O(OP_MUL), N(32'h10000), O(OP_EQ));
    add_vec(32'd9,  1'b0, 8, N(2), O(OP_ADD), N(3), O(OP_MUL), N(4), O(OP_SUB), N(5), O(OP_EQ));
    add_vec(32'd7,  1'b0, 2, N(7), O(OP_EQ));
    add_vec(32'd0,  1'b1, 3, O(OP_ADD), O(OP_EQ), N(5));
    add_vec(32'd0,  1'b1, 3, N(3), N(4), O(OP_EQ));
    add_vec(32'd0,  1'b1, 3, N(3), O(OP_ADD), O(OP_EQ));
    add_vec(32'd0,  1'b1, 4, N(3), O(4'hF), N(4), O(OP_EQ));

    #1 reset = 1'b1;
    #1;
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_error", {31'b0, error}, 32'd0);
    chk("reset_answer", answer, 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      pulse_reset();
      for (int j = 0; j < v.n; j++) send(v.tok[j]);
      wait_end();
      chk($sformatf("v%0d_answer", i), answer, v.ans);
      chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, !v.err});
      chk($sformatf("v%0d_error", i), {31'b0, error}, {31'b0, v.err});
      chk($sformatf("v%0d_ready", i), {31'b0, ready}, 32'd0);
    end

    // Equals latency with two pending reductions, then sticky done.
    pulse_reset();
    send(N(2)); send(O(OP_ADD)); send(N(3)); send(O(OP_MUL)); send(N(4)); send(O(OP_EQ));
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    chk("eq_latency", n, 32'd3);
    chk("eq_answer", answer, 32'd14);
    send(N(99));
    @(posedge clk); #1;
    chk("sticky_done", {31'b0, done}, 32'd1);
    chk("sticky_answer", answer, 32'd14);

    // Operator causing one reduction keeps ready low for two cycles.
    pulse_reset();
    send(N(5)); send(O(OP_MUL)); send(N(6)); send(O(OP_SUB));
    n = 0;
    while (!ready && n < 20) begin n++; @(posedge clk); #1; end
    chk("op_ready_low", n, 32'd2);
    send(N(7)); send(O(OP_EQ)); wait_end();
    chk("op_answer", answer, 32'd23);

    // Strobe while ready=0 is dropped.
    pulse_reset();
    send(N(2)); send(O(OP_ADD)); send(N(3)); send(O(OP_MUL));
    chk("busy_ready", {31'b0, ready}, 32'd0);
    token = 32'd9; token_is_op = 1'b0; strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
    send(N(4)); send(O(OP_EQ)); wait_end();
    chk("drop_answer", answer, 32'd14);
    chk("drop_error", {31'b0, error}, 32'd0);

    // Asynchronous reset in the middle of the final reduction.
    pulse_reset();
    send(N(2)); send(O(OP_ADD)); send(N(3)); send(O(OP_MUL)); send(N(4)); send(O(OP_EQ));
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, ready}, 32'd1);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_error", {31'b0, error}, 32'd0);
    chk("midrst_answer", answer, 32'd0);
    @(negedge clk) reset = 1'b0;
    send(N(1)); send(O(OP_ADD)); send(N(1)); send(O(OP_EQ)); wait_end();
    chk("after_rst_answer", answer, 32'd2);

    // Number push into a full stack (DEPTH=2 instance) errors.
    pulse_reset();
    send(N(1)); send(O(OP_ADD)); send(N(2)); send(O(OP_MUL)); send(N(3));
    @(posedge clk); #1;
    chk("full_error2", {31'b0, error2}, 32'd1);
    chk("full_answer2", answer2, 32'd0);
    chk("full_ok_error", {31'b0, error}, 32'd0);
    send(O(OP_EQ)); wait_end();
    chk("full_ok_answer", answer, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_calc_engine.md
# token_calc_engine

- Accepts the token stream emitted by the calculator control state machine:
  - decimal numbers built by the number builder;
  - operator codes from the keypad decoder.
- Evaluates the infix expression with operator precedence, using a two-stack scheme (number stack and operator stack).
- Returns the result on an `answer`/`done` handshake.
- Sits between the control state machine and the 7-segment/VGA answer path, replacing the ad-hoc calculator slot.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width.
- `DEPTH`, 4: entries in each stack.

Ports:
- `clk`, in, 1: single clock. Everything is synchronous to its rising edge.
- `reset`, in, 1: asynchronous, active-high. Clears all state.
- `strobe`, in, 1: token valid. Accepted only when `ready`=1; ignored otherwise.
- `token`, in, WIDTH: number value, or opcode in `[3:0]` when `token_is_op`=1.
- `token_is_op`, in, 1: 1 = operator/equals token, 0 = number token.
- `ready`, out, 1: engine can accept a token.
- `done`, out, 1: result valid; sticky until `reset`.
- `answer`, out, WIDTH: result; 0 unless `done`.
- `error`, out, 1: sequence/stack error; sticky until `reset`.

## Operation
- **Opcodes:**
  - 4'hA = add;
  - 4'hB = subtract;
  - 4'hC = multiply;
  - 4'hE = equals;
  - any other code with `token_is_op`=1 is an error.
- **Precedence:** multiply > add = subtract. All operators are left-associative.
- **Arithmetic:** two's-complement modulo 2^WIDTH. Multiply keeps the low WIDTH bits. No overflow flag.
- **Grammar:** tokens must alternate number, op, number, ..., equals. The first token must be a number.
- **States:**
  - IDLE: `ready`=1.
    - Number accepted: push it to the number stack (0-cycle); stay in IDLE.
    - Operator accepted: latch it into `pending_op`; go to REDUCE_OP.
    - Equals accepted: go to REDUCE_ALL.
  - REDUCE_OP: one action per cycle.
    - If op-stack top precedence >= `pending_op`: pop the op and two numbers (`a` = lower, `b` = top), push `a op b`.
    - Otherwise: push `pending_op` and return to IDLE.
  - REDUCE_ALL: one reduction per cycle while the op stack is non-empty. When it is empty: `answer` <= number top, go to DONE.
  - DONE: `done`=1, `ready`=0. Strobes are ignored until `reset`.
  - ERR: `error`=1, `ready`=0, `answer`=0. Strobes are ignored until `reset`.
- **Errors (enter ERR on the accepting edge):**
  - number after number;
  - op or equals first, or op/equals after op;
  - unknown opcode;
  - push to a full stack (push attempted with `DEPTH` entries present).
- Pop from an empty stack cannot occur if the grammar is enforced. The bench asserts this.

## Timing
- **Reset values:** `ready`=1, `done`=0, `error`=0, `answer`=0, both stacks empty, state IDLE.
- **Number token:** stack updated at the accept edge. `ready` stays 1, so back-to-back acceptance is legal.
- **Operator token:** `ready`=0 from the cycle after accept for k+1 cycles (k = reductions performed), then 1.
- **Equals token:** `done` rises k+1 cycles after the accept edge. `answer` is valid in the same cycle.
- **`reset` mid-reduction:** immediate return to reset values; no partial result is visible.
- A strobe coinciding with `ready`=0 is dropped with no state change.

## Structure
- Package `calc_pkg`:
  - opcode constants (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_EQ`);
  - state enum;
  - `prec()` function;
  - `apply_op()` function.
- Sub-module `lifo_stack` (parameters WIDTH, DEPTH):
  - push/pop with `top`, `count`, `full`, `empty`;
  - async reset;
  - instantiated twice: WIDTH-bit numbers, 4-bit ops.

## Test plan
- 2, A, 3, C, 4, E → `done` after 3 cycles, `answer`=14, `error`=0.
- 10, B, 4, B, 3, E → `answer`=3 (left associativity).
- 5, C, 6, B, 7, E → `answer`=23. The multiply reduces when B arrives; `ready` is low exactly 2 cycles after B.
- 32'hFFFFFFFF, A, 2, E → `answer`=1 (wrap). 32'h10000, C, 32'h10000, E → `answer`=0.
- Error cases, each → `error`=1, `answer`=0, later strobes ignored until `reset`:
  - A as first token;
  - 3, 4 (number after number);
  - 3, A, E (equals after op);
  - opcode 4'hF.
- Edge cases:
  - A strobe while `ready`=0 is ignored. For 2, A, 3, C (strobe 9 during reduction), 4, E → `answer`=14.
  - `reset` asserted mid-REDUCE_ALL → outputs return to reset values the same cycle. 1, A, 1, E afterwards → `answer`=2.
